if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the next-PC logic.
- Owns the architectural PC register and presents `pc` to next-PC logic; takes back `npc` when a redirect (branch/jump/jr/jalr) resolves.
- Issues word fetches to instruction memory over a req/gnt/rvalid handshake and buffers returned instructions in a small FIFO.
- Hands instructions to decode over a valid/ready interface.

---
 rtl/if_fetch_pkg.sv | 24 ++
 rtl/if_fifo.sv | 54 +++++
 rtl/if_fetch.sv | 135 +++++++++++++
 tb/tb_if_fetch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    // One buffered fetch: address of the instruction plus the word itself.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous instruction buffer with occupancy count and flush.
module if_fifo
    import if_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  if_entry_t     i_wdata,
    input  logic          i_pop,
    output if_entry_t     o_head,
    output logic [CW-1:0] o_count
);

    if_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != CW'(DEPTH)) || w_pop);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, pointers and count; flush empties without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, issues one fetch at a time, buffers returned words.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] npc,
    input  logic            redirect,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    if_state_e       r_state;
    if_state_e       w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_pend_pc;
    logic            r_pend_vld;
    logic            r_drop;
    logic [XLEN-1:0] w_target;
    logic            w_granted;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    logic            w_credit;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_next;
    if_entry_t       w_wdata;
    if_entry_t       w_head;

    assign w_target     = word_align(npc);
    assign w_granted    = (r_state == IF_REQ) && imem_gnt;
    assign w_resp       = (r_state == IF_WAIT) && imem_rvalid;
    assign w_push       = w_resp && !r_drop && !redirect;
    assign w_pop        = if_valid && if_ready;
    assign w_count_next = redirect ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    // Decided only when nothing is outstanding, so this is the full credit test.
    assign w_credit     = w_count_next < CW'(FIFO_DEPTH);
    assign w_wdata      = {r_req_pc, imem_rdata};

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign if_valid = (w_count != '0);
    assign if_instr = w_head.instr;
    assign if_pc    = w_head.pc;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: one request in flight, new request only with buffer credit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IF_IDLE: if (w_credit) w_state_next = IF_REQ;
            IF_REQ:  if (imem_gnt) w_state_next = IF_WAIT;
            IF_WAIT: if (imem_rvalid) w_state_next = w_credit ? IF_REQ : IF_IDLE;
            default: w_state_next = IF_IDLE;
        endcase
    end

    // FSM outputs: request held from assertion to grant with address from the PC.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        pc        = r_pc;
        if (r_state == IF_REQ) imem_req = 1'b1;
    end

    // PC, redirect-pending target, request address capture and drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_pend_pc  <= '0;
            r_pend_vld <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            if (w_granted) begin
                r_req_pc   <= r_pc;
                r_pend_vld <= 1'b0;
                if (redirect) begin
                    r_pc <= w_target;
                end else if (r_pend_vld) begin
                    r_pc <= r_pend_pc;
                end else begin
                    r_pc <= r_pc + 32'd4;
                end
            end else if (redirect) begin
                if (r_state == IF_REQ) begin
                    r_pend_vld <= 1'b1;
                    r_pend_pc  <= w_target;
                end else begin
                    r_pc <= w_target;
                end
            end

            if (redirect && ((r_state == IF_REQ) || ((r_state == IF_WAIT) && !imem_rvalid))) begin
                r_drop <= 1'b1;
            end else if (w_resp) begin
                r_drop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a stream-level reference model and a memory responder.
module tb_if_fetch;

    localparam logic [31:0] RST_PC  = 32'h0000_3000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
    localparam int unsigned DEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc = '0;
    logic        redirect = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_ready = 1'b1;

    logic [31:0] pc, imem_addr, if_instr, if_pc;
    logic        imem_req, if_valid;
    logic [31:0] pc1, imem_addr1, if_instr1, if_pc1;
    logic        imem_req1, if_valid1;

    if_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .npc(npc), .redirect(redirect),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
    );

    // Same stimulus, different reset PC: timing is address independent.
    if_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc(pc1), .npc(npc), .redirect(redirect),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid1), .if_ready(if_ready), .if_instr(if_instr1), .if_pc(if_pc1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Memory responder: grant unless holding, return data 'delay' cycles after grant.
    typedef struct { logic [31:0] addr; int due; } resp_t;
    resp_t rq[$];
    int rcyc  = 0;
    int hold  = 0;
    int delay = 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rcyc++;
            imem_rvalid = 1'b0;
            if (rq.size() > 0 && rq[0].due == rcyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(rq[0].addr);
                void'(rq.pop_front());
            end
            imem_gnt = 1'b0;
            if (imem_req) begin
                if (hold > 0) begin
                    hold--;
                end else begin
                    imem_gnt = 1'b1;
                    rq.push_back('{imem_addr, rcyc + delay});
                end
            end
        end
    end

    // Reference model: delivered PCs form a +4 stream restarting at each redirect target.
    int          m_count;
    bit          m_inflight, m_killed, m_pend;
    logic [31:0] m_pend_tgt, exp_fetch, exp_pc, tgt;
    bit          p_req, p_gnt, p_valid, p_ready, p_redir;
    logic [31:0] p_addr, p_ipc, p_instr;
    logic [31:0] q0[$], q1[$], cons[$];
    int          n_gnt;
    bit          push, pop;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req",    32'(imem_req), 32'd0);
                chk("rst_valid",  32'(if_valid), 32'd0);
                chk("rst_pc",     pc, RST_PC);
                chk("rst_addr",   imem_addr, RST_PC);
                chk("rst_if_pc",  if_pc, 32'd0);
                chk("rst_instr",  if_instr, 32'd0);
                chk("rst_wrap_pc", pc1, WRAP_PC);
                chk("rst_wrap_outs", 32'({imem_req1, if_valid1}) | if_pc1 | if_instr1, 32'd0);
                chk("rst_wrap_addr", imem_addr1, WRAP_PC);
                m_count = 0; m_inflight = 0; m_killed = 0; m_pend = 0; m_pend_tgt = '0;
                exp_fetch = RST_PC; exp_pc = RST_PC;
                p_req = 0; p_gnt = 0; p_valid = 0; p_ready = 0; p_redir = 0;
                p_addr = '0; p_ipc = '0; p_instr = '0;
                q0.delete(); q1.delete(); cons.delete(); n_gnt = 0;
            end else begin
                chk("valid_vs_model", 32'(if_valid), 32'(m_count != 0));
                if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
                if (p_req && !p_gnt) begin
                    chk("req_hold",  32'(imem_req), 32'd1);
                    chk("addr_hold", imem_addr, p_addr);
                end
                if (p_valid && !p_ready && !p_redir) begin
                    chk("valid_hold", 32'(if_valid), 32'd1);
                    chk("instr_hold", if_instr, p_instr);
                    chk("if_pc_hold", if_pc, p_ipc);
                end
                if (imem_req && imem_gnt) begin
                    chk("fetch_addr", imem_addr, exp_fetch);
                    q0.push_back(imem_addr);
                    n_gnt++;
                end
                if (imem_req1 && imem_gnt && q1.size() < 3) q1.push_back(imem_addr1);
                if (if_valid && if_ready) begin
                    chk("deliver_pc",    if_pc, exp_pc);
                    chk("deliver_instr", if_instr, memf(exp_pc));
                    cons.push_back(if_pc);
                end

                // Advance the model across the coming edge.
                tgt  = npc & 32'hFFFF_FFFC;
                pop  = (m_count != 0) && if_ready;
                push = 0;
                if (imem_rvalid && m_inflight) begin
                    push = !m_killed && !redirect;
                    m_inflight = 0;
                end
                if (pop) exp_pc = exp_pc + 32'd4;
                if (imem_req && imem_gnt) begin
                    m_inflight = 1;
                    m_killed   = redirect || m_pend;
                    if (redirect)    exp_fetch = tgt;
                    else if (m_pend) exp_fetch = m_pend_tgt;
                    else             exp_fetch = exp_fetch + 32'd4;
                    m_pend = 0;
                end else if (redirect) begin
                    if (imem_req) begin
                        m_pend = 1;
                        m_pend_tgt = tgt;
                    end else begin
                        exp_fetch = tgt;
                    end
                    if (m_inflight) m_killed = 1;
                end
                m_count = m_count + int'(push) - int'(pop);
                if (redirect) begin
                    m_count = 0;
                    exp_pc  = tgt;
                end

                p_req = imem_req; p_gnt = imem_gnt; p_addr = imem_addr;
                p_valid = if_valid; p_ready = if_ready; p_redir = redirect;
                p_ipc = if_pc; p_instr = if_instr;
            end
        end
    end

    function automatic logic [31:0] g_q0(input int i);
        return (i < q0.size()) ? q0[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] g_q1(input int i);
        return (i < q1.size()) ? q1[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] g_cons(input int i);
        return (i < cons.size()) ? cons[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic restart(input int d, input logic rdy);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        redirect = 1'b0;
        hold = 0;
        delay = d;
        if_ready = rdy;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_q0(input int n, input string name);
        int k = 0;
        while (q0.size() < n && k < 60) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (q0.size() < n) tmo(name);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Straight-line fetch, plus wrap-around on the second instance.
        restart(1, 1'b1);
        cycles(14);
        chk("p1_addr0", g_q0(0), 32'h0000_3000);
        chk("p1_addr1", g_q0(1), 32'h0000_3004);
        chk("p1_addr2", g_q0(2), 32'h0000_3008);
        chk("p1_pc0",   g_cons(0), 32'h0000_3000);
        chk("p1_pc1",   g_cons(1), 32'h0000_3004);
        chk("wrap0",    g_q1(0), 32'hFFFF_FFF8);
        chk("wrap1",    g_q1(1), 32'hFFFF_FFFC);
        chk("wrap2",    g_q1(2), 32'h0000_0000);

        // Backpressure: two entries buffered, no further requests.
        restart(1, 1'b0);
        cycles(10);
        chk("bp_grants", 32'(n_gnt), 32'd2);
        chk("bp_req",    32'(imem_req), 32'd0);
        chk("bp_valid",  32'(if_valid), 32'd1);
        chk("bp_if_pc",  if_pc, 32'h0000_3000);
        chk("bp_instr",  if_instr, memf(32'h0000_3000));
        if_ready = 1'b1;
        cycles(8);
        chk("bp_drain0", g_cons(0), 32'h0000_3000);
        chk("bp_drain1", g_cons(1), 32'h0000_3004);
        chk("bp_resume", g_q0(2), 32'h0000_3008);
        chk("bp_drain2", g_cons(2), 32'h0000_3008);

        // Redirect while 0x3008 is outstanding.
        restart(3, 1'b1);
        wait_q0(3, "rw_wait_3008");
        npc = 32'h0000_3040;
        redirect = 1'b1;
        cycles(1);
        redirect = 1'b0;
        chk("rw_empty", 32'(if_valid), 32'd0);
        cycles(14);
        chk("rw_next_addr", g_q0(3), 32'h0000_3040);
        chk("rw_first_pc",  g_cons(2), 32'h0000_3040);

        // Redirect during an ungranted request to 0x300C.
        restart(1, 1'b1);
        wait_q0(3, "ur_wait_3008");
        hold = 3;
        begin
            int k = 0;
            while (!(imem_req && imem_addr == 32'h0000_300C) && k < 20) begin
                cycles(1);
                k++;
            end
            if (!(imem_req && imem_addr == 32'h0000_300C)) tmo("ur_wait_req");
        end
        npc = 32'h0000_3101;
        redirect = 1'b1;
        cycles(1);
        redirect = 1'b0;
        chk("ur_hold_req1",  32'(imem_req), 32'd1);
        chk("ur_hold_addr1", imem_addr, 32'h0000_300C);
        cycles(1);
        chk("ur_hold_addr2", imem_addr, 32'h0000_300C);
        cycles(12);
        chk("ur_granted_old", g_q0(3), 32'h0000_300C);
        chk("ur_next_addr",   g_q0(4), 32'h0000_3100);
        chk("ur_consumed",    g_cons(2), 32'h0000_3008);
        chk("ur_first_pc",    g_cons(3), 32'h0000_3100);

        // Asynchronous reset between grant and response.
        restart(2, 1'b0);
        wait_q0(2, "ar_wait_grant");
        chk("ar_pre_valid", 32'(if_valid), 32'd1);
        chk("ar_pre_pc",    pc, 32'h0000_3008);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_pc",    pc, RST_PC);
        chk("ar_addr",  imem_addr, RST_PC);
        chk("ar_valid", 32'(if_valid), 32'd0);
        chk("ar_if_pc", if_pc, 32'd0);
        chk("ar_instr", if_instr, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        if_ready = 1'b1;
        cycles(12);
        chk("ar_restart", g_q0(0), RST_PC);
        chk("ar_pc0",     g_cons(0), 32'h0000_3000);
        chk("ar_pc1",     g_cons(1), 32'h0000_3004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
